serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial addition controller that time-shares a single full-adder cell (a, b, c → sum, carry) and a carry flip-flop to add two WIDTH-bit operands, one bit per clock, LSB first. It sits between a requesting master, which presents operands with a start pulse, and the one-bit adder datapath. It owns operand shifting, carry sequencing, bit counting and the start/done handshake. Results are held stable in output registers until the next operation completes.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- a  input  WIDTH  operand A. Captured on the accepting edge.
- b  input  WIDTH  operand B. Captured on the accepting edge.
- cin  input  1  carry-in. Captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse while in DONE.
- sum  output  WIDTH  registered result of the last completed operation.
- cout  output  1  registered carry-out of the last completed operation.
- ovf  output  1  signed overflow of the last completed operation. Present only with SERIAL_ADD_OVF_EN.

## Operation
- States and transitions:
  - IDLE → RUN on start=1.
  - RUN → DONE when the bit counter reaches WIDTH−1 on that edge.
  - DONE → IDLE unconditionally.
- On acceptance (IDLE, start=1):
  - a and b load into internal shift registers sa and sb.
  - carry register loads cin.
  - bit counter loads 0.
- Each RUN cycle evaluates the full-adder cell on (sa[0], sb[0], carry):
  - Cell sum shifts into the MSB of internal register ss; ss shifts right.
  - sa and sb shift right.
  - carry register loads the cell carry.
  - Counter increments.
- On the RUN→DONE edge:
  - sum loads the final ss value (including the bit computed this edge).
  - cout loads the final cell carry.
  - ovf loads (cell carry-in ^ cell carry-out) of the MSB step.
- sum, cout and ovf change only on the RUN→DONE edge. They hold their previous values during RUN, DONE and IDLE.
- start is ignored in RUN and DONE. No queuing: a request that is not accepted is lost.
- a, b and cin are don't-care after the accepting edge.
- Arithmetic: the result is {cout, sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1).
- Counter width is clog2(WIDTH)+1 bits, so there is no wrap for WIDTH=32.
- WIDTH=1: RUN lasts exactly one cycle.

## Timing
- Reset (asynchronous, any state):
  - Outputs: busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internals: state=IDLE; sa, sb, ss, carry and counter all cleared.
  - Reset during RUN aborts the operation. No done is produced, and no output register is updated.
- Latency, for start accepted at edge k:
  - busy is high in the cycles after edges k..k+WIDTH−1.
  - DONE is entered at edge k+WIDTH. done is high for exactly that one cycle, and sum/cout are valid from edge k+WIDTH.
  - IDLE is re-entered at edge k+WIDTH+1.
- Throughput: with start held high, the next operation is accepted at edge k+WIDTH+2. The repeat period is WIDTH+2 cycles.
- busy and done are never high simultaneously. Both are registered (decoded from state flops, no combinational path from inputs).
- Reset deassertion is synchronized externally. The first accept is possible on the first edge after rst falls.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - ovf port and its register exist.
  - ovf = (carry into MSB) XOR (carry out of MSB), i.e. signed two's-complement overflow.
  - Updated only on the RUN→DONE edge, with sum and cout.
- Not defined:
  - No ovf port and no associated logic.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- Basic add: a=8'h3C, b=8'h5A, cin=0, start at edge k → busy high for 8 cycles; done high for one cycle at edge k+8; sum=8'h96, cout=0, ovf=1.
- Carry chain: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0. Repeat with a=8'hFF, b=8'h00, cin=1 → sum=8'h00, cout=1.
- Ignored start: start an add of 8'h10+8'h20, then pulse start with a=8'hFF, b=8'hFF at edge k+3 → result is sum=8'h30, cout=0; exactly one done pulse.
- Hold/back-to-back: hold start=1 with constant operands 8'h01+8'h01 → done pulses at k+8, k+18, k+28 (period 10); sum=8'h02 stable between pulses; previous sum unchanged during RUN.
- Reset mid-operation: after a completed result sum=8'h96, start 8'h01+8'h01 and assert rst at edge k+4 → all outputs 0 immediately (asynchronously); no done pulse; a fresh start after rst deasserts completes normally with sum=8'h02.
- Config build: compile without SERIAL_ADD_OVF_EN and rerun scenarios 1–2 → sum, cout and done match exactly; ovf port is absent.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell plus a carry flop, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, ss_q, ss_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             cell_s, cell_c, last;
  logic [WIDTH-1:0] ss_shift;

  assign cell_s   = sa_q[0] ^ sb_q[0] ^ carry_q;
  assign cell_c   = (sa_q[0] & sb_q[0]) | (carry_q & (sa_q[0] ^ sb_q[0]));
  // Cell sum enters at the MSB; written as shifts so WIDTH=1 stays legal.
  assign ss_shift = (ss_q >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));
  assign last     = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ss_d    = ss_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        ss_d    = ss_shift;
        carry_d = cell_c;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          sum_d   = ss_shift;
          cout_d  = cell_c;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ cell_c;
`endif
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      ss_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ss_q    <= ss_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) against an arithmetic model.
// Honours SERIAL_ADD_OVF_EN the same way as the design.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: result of the last completed operation.
  logic [W-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_ovf;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
    int unsigned u;
    int          s;
    u        = int'(ma) + int'(mb) + int'(mc);
    exp_sum  = u[W-1:0];
    exp_cout = u[W];
    s        = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
    exp_ovf  = (s > 127) || (s < -128);
  endtask

  task automatic check_result(input string tag);
    check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`endif
  endtask

  // One operation; inj >= 0 drives a competing start/FF+FF after edge k+inj.
  task automatic do_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic oc, input int inj);
    logic [W-1:0] prev_sum;
    int           done_seen;
    prev_sum = exp_sum;
    done_seen = 0;
    a = oa; b = ob; cin = oc; start = 1'b1;
    step();
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      check({tag, "_busy"}, 64'(busy), 64'(1));
      if (done) done_seen++;
      check({tag, "_hold"}, 64'(sum), 64'(prev_sum));
      if (i == inj) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    model(oa, ob, oc);
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    check_result(tag);
    step();
    check({tag, "_done_clr"}, 64'(done), 64'(0));
    check({tag, "_idle"}, 64'(busy), 64'(0));
    check({tag, "_no_early_done"}, 64'(done_seen), 64'(0));
    // A dropped request must not start a second operation.
    step();
    check({tag, "_stay_idle"}, 64'(busy | done), 64'(0));
  endtask

  initial begin
    int bb_dones;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check_result("reset");
    step();
    rst = 1'b0;

    do_op("basic", 8'h3C, 8'h5A, 1'b0, -1);
    check("basic_const_sum", 64'(sum), 64'(8'h96));
    do_op("carry1", 8'hFF, 8'h01, 1'b0, -1);
    check("carry1_cout", 64'(cout), 64'(1));
    do_op("carry2", 8'hFF, 8'h00, 1'b1, -1);
    check("carry2_sum", 64'(sum), 64'(8'h00));
    do_op("ignored", 8'h10, 8'h20, 1'b0, 2);
    check("ignored_sum", 64'(sum), 64'(8'h30));

    for (int r = 0; r < 8; r++) begin
      do_op("rand", 8'($urandom), 8'($urandom), 1'($urandom), -1);
    end

    // Back-to-back with start held: accepts at k, k+10, k+20, k+30.
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    step();
    bb_dones = 0;
    for (int t = 1; t <= 39; t++) begin
      step();
      if (t == 30) start = 1'b0;
      check("b2b_busy", 64'(busy), 64'((t % 10) < 8));
      check("b2b_done", 64'(done), 64'((t % 10) == 8));
      if (done) bb_dones++;
      if (t == 8) model(8'h01, 8'h01, 1'b0);
      check("b2b_sum", 64'(sum), 64'(exp_sum));
    end
    check("b2b_done_count", 64'(bb_dones), 64'(4));
    check_result("b2b");

    // Re-establish a 0x96 result, then abort an operation with reset.
    do_op("pre_rst", 8'h3C, 8'h5A, 1'b0, -1);
    a = 8'h01; b = 8'h01; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    @(posedge clk);
    rst = 1'b1;
    #1;
    exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check_result("rst");
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("rst_no_done", 64'(done | busy), 64'(0));
      step();
    end
    check_result("rst_held");
    do_op("post_rst", 8'h01, 8'h01, 1'b0, -1);
    check("post_rst_sum", 64'(sum), 64'(8'h02));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
